// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and constants for the SPI transfer sequencer
package spi_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CFG_W  = 32;

  // Byte lanes of the configuration word handed to the core
  localparam int CFG_C1_LSB     = 24;
  localparam int CFG_C2_LSB     = 16;
  localparam int CFG_STATUS_LSB = 8;
  localparam int CFG_BAUD_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_KICK  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [7:0] cfg_field(input logic [31:0] cfg, input int lsb);
    return cfg[lsb +: 8];
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - first-word fall-through synchronous FIFO with registered flags
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_full,
  output logic             not_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push
  assign do_pop     = pop && not_empty;
  assign do_push    = push && (not_full || do_pop);
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

  // Pointers wrap naturally; flags are registered from the next-pointer values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      not_full  <= 1'b0;
      not_empty <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      not_full  <= !((wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]));
      not_empty <= (wr_ptr_nxt != rd_ptr_nxt);
    end
  end

  // Storage array needs no reset; empty entries are never presented
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = not_empty ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - counted burst sequencer feeding a single-byte SPI core
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CFG_W      = DEF_CFG_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic [CFG_W-1:0]  i_cfg,
  input  logic              i_cfg_wr,
  output logic              o_cfg_rej,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  input  logic              i_start,
  input  logic [7:0]        i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_core_data,
  output logic              o_core_trans_en,
  output logic [CFG_W-1:0]  o_core_cfg,
  input  logic              i_core_irq,
  input  logic [DATA_W-1:0] i_core_data
);

  state_t              state;
  logic [7:0]          cnt;
  logic [CFG_W-1:0]    cfg_q;
  logic [DATA_W-1:0]   core_data_q;
  logic [DATA_W-1:0]   rx_byte_q;
  logic                irq_q;
  logic                irq_rise;
  logic [DATA_W-1:0]   tx_head;
  logic                tx_not_full;
  logic                tx_not_empty;
  logic                tx_pop;
  logic                rx_not_full;
  logic                rx_not_empty;
  logic                rx_push;

  assign irq_rise = i_core_irq && !irq_q;
  assign tx_pop   = (state == ST_LOAD) && tx_not_empty;
  assign rx_push  = (state == ST_STORE) && rx_not_full;

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .push      (i_tx_valid),
    .wr_data   (i_tx_data),
    .pop       (tx_pop),
    .rd_data   (tx_head),
    .not_full  (tx_not_full),
    .not_empty (tx_not_empty)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (i_sys_clk),
    .rst       (i_sys_rst),
    .push      (rx_push),
    .wr_data   (rx_byte_q),
    .pop       (i_rx_ready),
    .rd_data   (o_rx_data),
    .not_full  (rx_not_full),
    .not_empty (rx_not_empty)
  );

  // Burst sequencer: one byte per LOAD-KICK-WAIT-STORE lap until the counter runs out
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      cfg_q       <= '0;
      core_data_q <= '0;
      rx_byte_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= i_core_irq;
      case (state)
        ST_IDLE: begin
          if (i_cfg_wr) begin
            cfg_q <= i_cfg;
          end
          if (i_start && (i_len != 8'd0)) begin
            cnt   <= i_len;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (tx_pop) begin
            core_data_q <= tx_head;
            state       <= ST_KICK;
          end
        end
        ST_KICK: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (irq_rise) begin
            rx_byte_q <= i_core_data;
            state     <= ST_STORE;
          end
        end
        ST_STORE: begin
          if (rx_push) begin
            cnt   <= cnt - 8'd1;
            state <= (cnt == 8'd1) ? ST_DONE : ST_LOAD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy          = (state != ST_IDLE);
  assign o_done          = (state == ST_DONE);
  assign o_core_trans_en = (state == ST_KICK);
  assign o_cfg_rej       = i_cfg_wr && (state != ST_IDLE);
  assign o_core_data     = core_data_q;
  assign o_core_cfg      = cfg_q;
  assign o_tx_ready      = tx_not_full;
  assign o_rx_valid      = rx_not_empty;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - randomized self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg = '0;
  logic        cfg_wr = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        rx_ready;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        core_irq = 1'b0;
  logic [7:0]  core_din = '0;

  logic        cfg_rej, tx_ready, rx_valid, busy, done, trans_en;
  logic [7:0]  rx_data, core_dout;
  logic [31:0] core_cfg;

  spi_xfer_ctrl #(.DATA_W(8), .CFG_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_cfg           (cfg),
    .i_cfg_wr        (cfg_wr),
    .o_cfg_rej       (cfg_rej),
    .i_tx_data       (tx_data),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (tx_ready),
    .o_rx_data       (rx_data),
    .o_rx_valid      (rx_valid),
    .i_rx_ready      (rx_ready),
    .i_start         (start),
    .i_len           (len),
    .o_busy          (busy),
    .o_done          (done),
    .o_core_data     (core_dout),
    .o_core_trans_en (trans_en),
    .o_core_cfg      (core_cfg),
    .i_core_irq      (core_irq),
    .i_core_data     (core_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state (written only by the compare process)
  logic [7:0]  tx_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  rx_log[$];
  int          trans_cyc_q[$];
  logic [31:0] m_cfg = '0;
  bit          m_busy = 0;
  int          trans_left = 0;
  int          done_cnt = 0;
  int          rej_cnt = 0;
  int          pend_in = 0;
  int          rx_idx = 0;
  int          last_trans_cyc = 0;
  int          last_push_cyc = 0;
  bit          just_rel = 1;

  // Core responder state (written only by the responder)
  logic [7:0]  resp_log[$];
  int          pend_out = 0;
  int          resp_rd = 0;
  int          resp_d, resp_h;

  // Knobs written only by the stimulus process
  logic [7:0]  resp_q[$];
  bit          resp_en = 1;
  int          resp_d_lo = 1, resp_d_hi = 4, hold_lo = 1, hold_hi = 3;
  int          rx_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle index used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Host RX side: low, high or random ready
  always begin
    @(posedge clk);
    #1;
    rx_ready = (rx_mode == 2) ? 1'($urandom_range(1, 0)) : (rx_mode == 1);
  end

  // Core model: each trans_en is answered by one irq rise carrying a reply byte
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      pend_out = pend_in;
    end else if (resp_en && pend_in > pend_out) begin
      resp_d = $urandom_range(resp_d_hi, resp_d_lo);
      repeat (resp_d - 1) step();
      if (resp_rd < resp_q.size()) begin
        core_din = resp_q[resp_rd];
        resp_rd++;
      end else begin
        core_din = 8'($urandom);
      end
      core_irq = 1'b1;
      resp_log.push_back(core_din);
      resp_h = $urandom_range(hold_hi, hold_lo);
      repeat (resp_h) step();
      core_irq = 1'b0;
      pend_out++;
    end
  end

  // Compare process: checks every cycle against the transaction-level model
  always @(negedge clk) begin
    if (rst) begin
      tx_q.delete();
      m_busy = 0;
      trans_left = 0;
      m_cfg = '0;
      rx_idx = resp_log.size();
      just_rel = 1;
    end else begin
      check("cfg", core_cfg, m_cfg);
      check("busy", busy, m_busy);
      check("cfg_rej", cfg_rej, cfg_wr && m_busy);
      if (cfg_rej) rej_cnt++;
      if (trans_en) begin
        check("trans_ctx", m_busy && trans_left > 0 && tx_q.size() > 0, 1);
        if (tx_q.size() > 0) begin
          check("core_data", core_dout, tx_q[0]);
          void'(tx_q.pop_front());
        end
        tx_log.push_back(core_dout);
        trans_cyc_q.push_back(cyc);
        trans_left--;
        pend_in++;
        last_trans_cyc = cyc;
      end
      check("tx_ready", tx_ready, !just_rel && tx_q.size() < DEPTH);
      if (just_rel) check("rx_valid_rel", rx_valid, 0);
      if (rx_valid) check("rx_avail", resp_log.size() > rx_idx, 1);
      if (done) begin
        check("done_ctx", m_busy && trans_left == 0, 1);
        done_cnt++;
      end
      if (rx_valid && rx_ready && resp_log.size() > rx_idx) begin
        check("rx_data", rx_data, resp_log[rx_idx]);
        rx_log.push_back(rx_data);
        rx_idx++;
      end
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        last_push_cyc = cyc;
      end
      if (!m_busy && cfg_wr) m_cfg = cfg;
      if (done) m_busy = 0;
      else if (!m_busy && start && len != 8'd0) begin
        m_busy = 1;
        trans_left = int'(len);
      end
      just_rel = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 500) begin step(); n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL push_timeout actual=blocked required=ready");
    end else begin
      tx_valid = 1'b1; tx_data = b;
      step();
      tx_valid = 1'b0;
    end
  endtask

  task automatic cfg_start(input logic w, input logic [31:0] c, input logic s, input logic [7:0] l);
    cfg_wr = w; cfg = c; start = s; len = l;
    step();
    cfg_wr = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int lim, input string name);
    int n = 0;
    while (done_cnt == prev && n < lim) begin step(); n++; end
    check(name, done_cnt, prev + 1);
  endtask

  int tb0, rb0, d0, s0, r0, n0;
  logic [31:0] rc;
  logic [7:0]  rl;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("reset_outputs", {cfg_rej, tx_ready, rx_valid, busy, done, trans_en, core_dout, core_cfg, rx_data}, 64'd0);
    rst = 1'b0;
    step(); step();
    check("idle_tx_ready", tx_ready, 1);

    // Basic two-byte burst with known bytes
    cfg_start(1, 32'hD610_8011, 0, 0);
    resp_q.push_back(8'h5A); resp_q.push_back(8'hC3);
    push_byte(8'hA5); push_byte(8'h3C);
    tb0 = tx_log.size(); rb0 = rx_log.size(); d0 = done_cnt; s0 = cyc;
    cfg_start(0, 0, 1, 8'd2);
    wait_done(d0, 500, "basic_done");
    repeat (10) step();
    check("basic_cfg", core_cfg, 32'hD610_8011);
    check("basic_ntrans", tx_log.size() - tb0, 2);
    check("basic_nrx", rx_log.size() - rb0, 2);
    if (tx_log.size() - tb0 == 2) begin
      check("basic_tx0", tx_log[tb0], 8'hA5);
      check("basic_tx1", tx_log[tb0+1], 8'h3C);
      check("basic_lat", trans_cyc_q[tb0] - s0, 2);
    end
    if (rx_log.size() - rb0 == 2) begin
      check("basic_rx0", rx_log[rb0], 8'h5A);
      check("basic_rx1", rx_log[rb0+1], 8'hC3);
    end
    check("basic_ndone", done_cnt - d0, 1);

    // TX underflow stalls in LOAD; each kick follows its push by 2 cycles
    tb0 = tx_log.size(); d0 = done_cnt;
    cfg_start(0, 0, 1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (20) step();
      if (i == 0) begin
        check("stall_busy", busy, 1);
        check("stall_no_trans", tx_log.size() - tb0, 0);
      end
      push_byte(8'($urandom));
      repeat (4) step();
      check("stall_lat", last_trans_cyc - last_push_cyc, 2);
    end
    wait_done(d0, 500, "stall_done");
    check("stall_ntrans", tx_log.size() - tb0, 3);
    repeat (10) step();

    // RX backpressure: 10-byte burst holds on byte 9 until the host reads
    rx_mode = 0;
    step(); step();
    tb0 = tx_log.size(); rb0 = rx_log.size(); d0 = done_cnt;
    cfg_start(0, 0, 1, 8'd10);
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    repeat (300) step();
    check("rxfull_trans", tx_log.size() - tb0, 9);
    check("rxfull_busy", busy, 1);
    check("rxfull_nodone", done_cnt, d0);
    rx_mode = 1;
    wait_done(d0, 2000, "rxfull_done");
    repeat (15) step();
    check("rxfull_nrx", rx_log.size() - rb0, 10);

    // Held irq must not retrigger; config write while busy is rejected
    resp_d_lo = 2; resp_d_hi = 3; hold_lo = 5; hold_hi = 5;
    tb0 = tx_log.size(); rb0 = rx_log.size(); d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    cfg_start(0, 0, 1, 8'd3);
    n0 = 0;
    while (tx_log.size() == tb0 && n0 < 100) begin step(); n0++; end
    check("wait_seen", tx_log.size() - tb0, 1);
    r0 = rej_cnt;
    cfg_start(1, 32'h1234_5678, 0, 0);
    check("rej_pulse", rej_cnt - r0, 1);
    check("rej_cfg_kept", core_cfg, 32'hD610_8011);
    wait_done(d0, 1000, "hold_done");
    repeat (15) step();
    check("hold_ntrans", tx_log.size() - tb0, 3);
    check("hold_nrx", rx_log.size() - rb0, 3);
    resp_d_lo = 1; resp_d_hi = 4; hold_lo = 1; hold_hi = 3;

    // Reset while waiting on the core mid-burst
    resp_en = 0;
    tb0 = tx_log.size(); d0 = done_cnt;
    push_byte(8'h11); push_byte(8'h22);
    cfg_start(0, 0, 1, 8'd2);
    n0 = 0;
    while (tx_log.size() == tb0 && n0 < 100) begin step(); n0++; end
    step();
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", {cfg_rej, tx_ready, rx_valid, busy, done, trans_en, core_dout, core_cfg, rx_data}, 64'd0);
    step(); step();
    rst = 1'b0;
    step(); step();
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_cfg", core_cfg, 32'd0);
    check("rst_no_done", done_cnt, d0);
    resp_en = 1;

    // Zero-length start is ignored
    push_byte(8'h77);
    tb0 = tx_log.size(); d0 = done_cnt;
    cfg_start(0, 0, 1, 8'd0);
    repeat (10) step();
    check("len0_busy", busy, 0);
    check("len0_no_trans", tx_log.size() - tb0, 0);
    check("len0_no_done", done_cnt, d0);

    // Random bursts with same-cycle config+start and random host/core timing
    rx_mode = 2;
    for (int it = 0; it < 8; it++) begin
      rl = 8'($urandom_range(12, 1));
      rc = $urandom;
      resp_d_hi = $urandom_range(6, 1);
      hold_hi = $urandom_range(6, 1);
      d0 = done_cnt;
      cfg_start(1, rc, 1, rl);
      for (int j = 0; j < int'(rl); j++) push_byte(8'($urandom));
      wait_done(d0, 3000, "rand_done");
      check("rand_cfg", core_cfg, rc);
      repeat (10) step();
    end
    rx_mode = 1;
    repeat (40) step();
    check("final_drain", resp_log.size() - rx_idx, 0);
    check("final_rx_valid", rx_valid, 0);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
